// File: rtl/pad_cfg_ctrl_if.sv
// Serial configuration port of pad_cfg_ctrl: frame select, serial clock, data in and readback data out.
interface pad_cfg_ctrl_if;
  logic cfg_csn;
  logic cfg_sck;
  logic cfg_sdi;
  logic cfg_sdo;

  modport master (output cfg_csn, output cfg_sck, output cfg_sdi, input cfg_sdo);
  modport slave  (input cfg_csn, input cfg_sck, input cfg_sdi, output cfg_sdo);
endinterface

// File: rtl/pad_cfg_ctrl.sv
// Serial-framed bidirectional pad configuration controller (16-bit frames, unicast or broadcast).
// Optional status readback on cfg_sdo is enabled by defining PAD_CFG_READBACK_EN.
module pad_cfg_ctrl #(
  parameter int unsigned NUM_BIDIR_PADS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  pad_cfg_ctrl_if.slave             cfg,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  output logic                      busy,
  output logic                      frame_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [7:0] PAD_LIMIT = 8'(NUM_BIDIR_PADS);

  logic [1:0]  state;
  logic        csn_s1, csn_s2, csn_q;
  logic        sck_s1, sck_s2, sck_q;
  logic        sdi_s1, sdi_s2;
  logic [1:0]  sync_fill;
  logic        armed;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_sr;

  logic        csn_fall, csn_rise, sck_rise, sck_fall;
  logic        frame_open;
  logic        f_bcast;
  logic [6:0]  f_addr;
  logic [5:0]  f_cfg;
  logic        addr_ok;
  logic        commit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      csn_s1    <= 1'b1;
      csn_s2    <= 1'b1;
      csn_q     <= 1'b1;
      sck_s1    <= 1'b0;
      sck_s2    <= 1'b0;
      sck_q     <= 1'b0;
      sdi_s1    <= 1'b0;
      sdi_s2    <= 1'b0;
      sync_fill <= '0;
      armed     <= 1'b0;
    end else begin
      csn_s1    <= cfg.cfg_csn;
      csn_s2    <= csn_s1;
      csn_q     <= csn_s2;
      sck_s1    <= cfg.cfg_sck;
      sck_s2    <= sck_s1;
      sck_q     <= sck_s2;
      sdi_s1    <= cfg.cfg_sdi;
      sdi_s2    <= sdi_s1;
      sync_fill <= {sync_fill[0], 1'b1};
      // The synchroniser resets to csn high, so a low csn held across reset would
      // look like a falling edge; only arm once a genuine high level has propagated.
      armed     <= armed | (sync_fill[1] & csn_s2);
    end
  end

  always_comb begin
    csn_fall   = csn_q & ~csn_s2;
    csn_rise   = ~csn_q & csn_s2;
    sck_rise   = ~sck_q & sck_s2;
    sck_fall   = sck_q & ~sck_s2;
    frame_open = (state == IDLE) && csn_fall && armed;
    f_bcast    = shift_sr[15];
    f_addr     = shift_sr[14:8];
    f_cfg      = shift_sr[5:0];
    addr_ok    = ({1'b0, f_addr} < PAD_LIMIT);
    commit_ok  = (state == COMMIT) && (f_bcast || addr_ok);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_sr  <= '0;
      frame_err <= 1'b0;
      bidir_oe  <= '0;
      bidir_cs  <= '0;
      bidir_sl  <= '0;
      bidir_ie  <= '1;
      bidir_pu  <= '0;
      bidir_pd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_open) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            shift_sr <= '0;
          end
        end
        SHIFT: begin
          // A frame close wins over a coincident sck edge, which is dropped.
          if (csn_rise) begin
            if (bit_cnt == 5'd16) begin
              state <= COMMIT;
            end else begin
              state     <= IDLE;
              frame_err <= 1'b1;
            end
          end else if (sck_rise) begin
            shift_sr <= {shift_sr[14:0], sdi_s2};
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (commit_ok) begin
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_BIDIR_PADS; i++) begin
              if (f_bcast || (f_addr == 7'(i))) begin
                bidir_oe[i] <= f_cfg[5];
                bidir_cs[i] <= f_cfg[4];
                bidir_sl[i] <= f_cfg[3];
                bidir_ie[i] <= f_cfg[2];
                bidir_pu[i] <= f_cfg[1];
                bidir_pd[i] <= f_cfg[0];
              end
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PAD_CFG_READBACK_EN
  logic [15:0] rb_sr;
  logic [6:0]  last_addr;
  logic [5:0]  last_cfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_sr     <= '0;
      last_addr <= '0;
      last_cfg  <= '0;
    end else begin
      if (commit_ok) begin
        last_addr <= f_addr;
        last_cfg  <= f_cfg;
      end
      if (frame_open) begin
        rb_sr <= {frame_err, 1'b0, last_addr, last_cfg, 1'b0};
      end else if (state == SHIFT && !csn_rise) begin
        if (sck_fall) rb_sr <= {rb_sr[14:0], 1'b0};
      end else begin
        rb_sr <= '0;
      end
    end
  end

  assign cfg.cfg_sdo = rb_sr[15];
`else
  assign cfg.cfg_sdo = 1'b0;
`endif

endmodule
